// File: rtl/alu.sv
// Matrix ALU for 5x5 signed 8-bit operands: registered elementwise, product,
// transpose and scalar ops, plus a multi-cycle fraction-free determinant engine.
module alu (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op_code,
  input  logic [1:0]   matrix_size,
  input  logic [199:0] matrix_a,
  input  logic [199:0] matrix_b,
  input  logic [7:0]   scalar,
  output logic [199:0] result_final,
  output logic         overflow
);

  // Bareiss intermediates reach products of two 4x4 minors, so 64 bits is not enough.
  localparam int DW = 80;
  localparam logic signed [DW-1:0] MIN8 = -128;
  localparam logic signed [DW-1:0] MAX8 = 127;
  localparam logic signed [DW-1:0] ONE  = 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SCL = 3'b011;
  localparam logic [2:0] OP_TRN = 3'b100;
  localparam logic [2:0] OP_NEG = 3'b101;
  localparam logic [2:0] OP_DET = 3'b110;

  typedef enum logic [1:0] {IDLE, LOAD, ELIM, DONE} state_t;

  state_t               state_q;
  logic signed [DW-1:0] work_q [5][5];
  logic signed [DW-1:0] prevPivot_q;
  logic                 negSign_q;
  logic [2:0]           k_q, i_q, n_q;
  logic [7:0]           detByte_q;
  logic                 detOvf_q, detValid_q;
  logic [199:0]         result_q;
  logic                 overflow_q;

  logic [2:0]           nAct;
  logic [199:0]         result_d;
  logic                 overflow_d;
  logic signed [DW-1:0] rowNew [5];
  logic signed [DW-1:0] pivot, divisor, lastDiag, detFull;
  logic                 swapFound;
  logic [2:0]           swapRow;

  assign nAct         = {1'b0, matrix_size} + 3'd2;
  assign result_final = result_q;
  assign overflow     = overflow_q;

  function automatic logic signed [31:0] elem(input logic [199:0] m, input int r, input int c);
    return {{24{m[8*(r*5+c)+7]}}, m[8*(r*5+c) +: 8]};
  endfunction

  function automatic logic signed [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  always_comb begin
    logic signed [31:0] full;
    result_d   = '0;
    overflow_d = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        full = '0;
        case (op_code)
          OP_ADD: full = elem(matrix_a, r, c) + elem(matrix_b, r, c);
          OP_SUB: full = elem(matrix_a, r, c) - elem(matrix_b, r, c);
          OP_MUL: begin
            for (int k = 0; k < 5; k++)
              if (k < int'(nAct))
                full = full + elem(matrix_a, r, k) * elem(matrix_b, k, c);
          end
          OP_SCL: full = sext8(scalar) * elem(matrix_a, r, c);
          OP_TRN: full = elem(matrix_a, c, r);
          OP_NEG: full = -elem(matrix_a, r, c);
          default: full = '0;
        endcase
        if (r < int'(nAct) && c < int'(nAct)) begin
          result_d[8*(r*5+c) +: 8] = full[7:0];
          if (full < -32'sd128 || full > 32'sd127)
            overflow_d = 1'b1;
        end
      end
    end
  end

  // One Bareiss row update per cycle, plus the search for a replacement pivot row.
  always_comb begin
    pivot    = work_q[k_q][k_q];
    divisor  = (prevPivot_q == '0) ? ONE : prevPivot_q;
    lastDiag = work_q[n_q - 3'd1][n_q - 3'd1];
    detFull  = negSign_q ? -lastDiag : lastDiag;
    for (int j = 0; j < 5; j++)
      rowNew[j] = (pivot * work_q[i_q][j] - work_q[i_q][k_q] * work_q[k_q][j]) / divisor;
    swapFound = 1'b0;
    swapRow   = k_q;
    for (int r = 0; r < 5; r++) begin
      if (!swapFound && r > int'(k_q) && r < int'(n_q) && work_q[r][k_q] != '0) begin
        swapFound = 1'b1;
        swapRow   = 3'(r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      prevPivot_q <= '0;
      negSign_q   <= 1'b0;
      k_q         <= '0;
      i_q         <= '0;
      n_q         <= '0;
      detByte_q   <= '0;
      detOvf_q    <= 1'b0;
      detValid_q  <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          work_q[r][c] <= '0;
    end else if (op_code != OP_DET) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            n_q     <= nAct;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              work_q[r][c] <= (r < int'(n_q) && c < int'(n_q)) ? DW'(elem(matrix_a, r, c)) : '0;
          negSign_q   <= 1'b0;
          prevPivot_q <= ONE;
          k_q         <= 3'd0;
          i_q         <= 3'd1;
          state_q     <= ELIM;
        end
        ELIM: begin
          if (k_q == n_q - 3'd1) begin
            detByte_q  <= detFull[7:0];
            detOvf_q   <= (detFull < MIN8) || (detFull > MAX8);
            detValid_q <= 1'b1;
            state_q    <= DONE;
          end else if (pivot == '0) begin
            if (swapFound) begin
              for (int j = 0; j < 5; j++) begin
                work_q[k_q][j]     <= work_q[swapRow][j];
                work_q[swapRow][j] <= work_q[k_q][j];
              end
              negSign_q <= ~negSign_q;
            end else begin
              detByte_q  <= '0;
              detOvf_q   <= 1'b0;
              detValid_q <= 1'b1;
              state_q    <= DONE;
            end
          end else begin
            for (int j = 0; j < 5; j++)
              work_q[i_q][j] <= rowNew[j];
            if (i_q == n_q - 3'd1) begin
              prevPivot_q <= pivot;
              k_q         <= k_q + 3'd1;
              i_q         <= k_q + 3'd2;
            end else begin
              i_q <= i_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (op_code == OP_DET) begin
      result_q   <= detValid_q ? {192'd0, detByte_q} : '0;
      overflow_q <= detValid_q & detOvf_q;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for the matrix ALU: table of vectors streamed through a scoreboard, plus
// hand-written determinant, reset and abort sequences checked against a local model.
module tb_alu;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   opCode;
  logic [1:0]   matrixSize;
  logic [199:0] matA, matB;
  logic [7:0]   scalarIn;
  logic [199:0] resultFinal;
  logic         overflowOut;

  alu dut (
    .clk(clk), .rst(rst), .start(start), .op_code(opCode), .matrix_size(matrixSize),
    .matrix_a(matA), .matrix_b(matB), .scalar(scalarIn),
    .result_final(resultFinal), .overflow(overflowOut)
  );

  always #5 clk = ~clk;

  typedef struct { logic [199:0] res; logic ovf; } expect_t;
  typedef struct { logic [2:0] op; logic [1:0] size; int matSel; logic [7:0] scl; } vec_t;

  expect_t      expQ[$];
  vec_t         vecs[20];
  int           assertCount = 0;
  int           failCount = 0;
  logic [199:0] specA, specB, rndA, rndB, extA, extB;

  function automatic int elemOf(input logic [199:0] m, input int r, input int c);
    logic signed [7:0] b;
    b = m[8*(r*5+c) +: 8];
    return int'(b);
  endfunction

  function automatic logic [199:0] pack(input int v[25]);
    logic [199:0] p;
    for (int i = 0; i < 25; i++) p[8*i +: 8] = 8'(v[i]);
    return p;
  endfunction

  function automatic void model(input logic [2:0] op, input logic [1:0] sz,
                                input logic [199:0] a, input logic [199:0] b,
                                input logic [7:0] s, output logic [199:0] r, output logic ov);
    int n;
    longint v;
    logic signed [7:0] ss;
    ss = s;
    n = int'(sz) + 2;
    r = '0;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (op)
          3'b000: v = elemOf(a, i, j) + elemOf(b, i, j);
          3'b001: v = elemOf(a, i, j) - elemOf(b, i, j);
          3'b010: begin
            v = 0;
            for (int k = 0; k < n; k++) v += elemOf(a, i, k) * elemOf(b, k, j);
          end
          3'b011: v = int'(ss) * elemOf(a, i, j);
          3'b100: v = elemOf(a, j, i);
          3'b101: v = -elemOf(a, i, j);
          default: v = 0;
        endcase
        r[8*(i*5+j) +: 8] = v[7:0];
        if (v < -128 || v > 127) ov = 1'b1;
      end
    end
  endfunction

  // Leibniz expansion over all index tuples; sign from inversion count.
  function automatic longint detModel(input logic [199:0] a, input int n);
    longint total, prod;
    int idx[5];
    int limit, tmp, inv;
    bit ok;
    total = 0;
    limit = 1;
    for (int t = 0; t < n; t++) limit *= n;
    for (int code = 0; code < limit; code++) begin
      tmp = code;
      for (int t = 0; t < n; t++) begin
        idx[t] = tmp % n;
        tmp = tmp / n;
      end
      ok = 1'b1;
      inv = 0;
      for (int p = 0; p < n; p++)
        for (int q = p + 1; q < n; q++) begin
          if (idx[p] == idx[q]) ok = 1'b0;
          if (idx[p] > idx[q]) inv++;
        end
      if (ok) begin
        prod = 1;
        for (int t = 0; t < n; t++) prod *= elemOf(a, t, idx[t]);
        total += (inv % 2 == 1) ? -prod : prod;
      end
    end
    return total;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] sz, input logic [199:0] a,
                               input logic [199:0] b, input logic [7:0] s, input logic st);
    opCode = op;
    matrixSize = sz;
    matA = a;
    matB = b;
    scalarIn = s;
    start = st;
  endtask

  task automatic pushExp(input logic [199:0] r, input logic o);
    expect_t e;
    e.res = r;
    e.ovf = o;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    expect_t e;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL %s: no expected entry, got result=%h ovf=%b", name, resultFinal, overflowOut);
    end else begin
      e = expQ.pop_front();
      if (resultFinal !== e.res || overflowOut !== e.ovf) begin
        failCount++;
        $display("[TB] FAIL %s: got result=%h ovf=%b, expected result=%h ovf=%b",
                 name, resultFinal, overflowOut, e.res, e.ovf);
      end
    end
  endtask

  task automatic checkSpot(input string name, input int idx, input logic [7:0] v);
    assertCount++;
    if (resultFinal[8*idx +: 8] !== v) begin
      failCount++;
      $display("[TB] FAIL %s: element %0d got %h, expected %h", name, idx, resultFinal[8*idx +: 8], v);
    end
  endtask

  task automatic checkOvf(input string name, input logic v);
    assertCount++;
    if (overflowOut !== v) begin
      failCount++;
      $display("[TB] FAIL %s: overflow got %b, expected %b", name, overflowOut, v);
    end
  endtask

  task automatic runDet(input string name, input logic [199:0] a, input logic [1:0] sz, input bit withReset);
    longint d;
    logic [199:0] r;
    if (withReset) begin
      applyStimulus(3'b110, sz, a, '0, 8'd0, 1'b0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      pushExp('0, 1'b0);
      checkOutput({name, "_rst"});
    end
    applyStimulus(3'b110, sz, a, '0, 8'd0, 1'b1);
    step();
    start = 1'b0;
    repeat (31) step();
    d = detModel(a, int'(sz) + 2);
    r = '0;
    r[7:0] = d[7:0];
    pushExp(r, (d < -128 || d > 127));
    checkOutput({name, "_det"});
  endtask

  initial begin
    int av[25] = '{2,32,12,6,10, 5,18,39,7,17, 4,69,26,10,42, 3,9,16,24,32, 8,3,25,3,27};
    int bv[25] = '{8,14,94,54,61, 76,1,0,43,18, 41,38,67,22,9, 6,8,42,90,20, 15,25,7,63,12};
    int sing[25] = '{1,2,3,0,0, 2,4,6,0,0, 0,0,1,0,0, 0,0,0,0,0, 0,0,0,0,0};
    int swp3[25] = '{0,2,1,0,0, 3,1,4,0,0, 5,2,6,0,0, 0,0,0,0,0, 0,0,0,0,0};
    int swp4[25] = '{0,1,2,3,0, 0,0,1,4,0, 2,1,0,1,0, 1,3,1,0,0, 0,0,0,0,0};
    int m3[25]   = '{3,1,2,0,0, 1,4,1,0,0, 2,0,5,0,0, 0,0,0,0,0, 0,0,0,0,0};
    logic [199:0] a, b, r, small5, full5;
    logic o;

    specA = pack(av);
    specB = pack(bv);
    for (int i = 0; i < 25; i++) begin
      rndA[8*i +: 8]   = 8'($urandom_range(0, 255));
      rndB[8*i +: 8]   = 8'($urandom_range(0, 255));
      extA[8*i +: 8]   = (i % 2 == 0) ? 8'h80 : 8'h7F;
      extB[8*i +: 8]   = 8'h80;
      small5[8*i +: 8] = 8'(int'($urandom_range(0, 6)) - 3);
      full5[8*i +: 8]  = 8'($urandom_range(0, 255));
    end
    small5[7:0] = 8'h00;

    vecs[0]  = '{3'b000, 2'b11, 0, 8'd0};
    vecs[1]  = '{3'b001, 2'b11, 0, 8'd0};
    vecs[2]  = '{3'b010, 2'b11, 0, 8'd0};
    vecs[3]  = '{3'b011, 2'b11, 0, 8'd3};
    vecs[4]  = '{3'b100, 2'b11, 0, 8'd0};
    vecs[5]  = '{3'b101, 2'b11, 0, 8'd0};
    vecs[6]  = '{3'b111, 2'b11, 0, 8'd0};
    vecs[7]  = '{3'b000, 2'b00, 0, 8'd0};
    vecs[8]  = '{3'b010, 2'b01, 0, 8'd0};
    vecs[9]  = '{3'b100, 2'b00, 0, 8'd0};
    vecs[10] = '{3'b101, 2'b10, 2, 8'd0};
    vecs[11] = '{3'b000, 2'b11, 2, 8'd0};
    vecs[12] = '{3'b011, 2'b10, 1, 8'h80};
    vecs[13] = '{3'b010, 2'b11, 1, 8'd0};
    vecs[14] = '{3'b001, 2'b01, 1, 8'd0};
    vecs[15] = '{3'b000, 2'b10, 1, 8'd0};
    vecs[16] = '{3'b010, 2'b00, 2, 8'd0};
    vecs[17] = '{3'b011, 2'b11, 2, 8'd1};
    vecs[18] = '{3'b101, 2'b11, 1, 8'd0};
    vecs[19] = '{3'b100, 2'b01, 1, 8'd0};

    rst = 1'b0;
    applyStimulus(3'b000, 2'b11, specA, specB, 8'd0, 1'b0);
    step();
    pushExp('0, 1'b0);
    checkOutput("reset_state");
    rst = 1'b1;

    // Known-answer vectors with hand-derived element values.
    step();
    checkSpot("add_e0", 0, 8'd10);
    checkSpot("add_e1", 1, 8'd46);
    checkSpot("add_e2", 2, 8'd106);
    checkSpot("add_e11", 11, 8'd107);
    checkOvf("add_ovf", 1'b0);
    applyStimulus(3'b011, 2'b11, specA, specB, 8'd3, 1'b0);
    step();
    checkSpot("scl_e0", 0, 8'd6);
    checkSpot("scl_e11", 11, 8'hCF);
    checkOvf("scl_ovf", 1'b1);
    applyStimulus(3'b001, 2'b11, specA, specB, 8'd0, 1'b0);
    step();
    checkSpot("sub_e0", 0, 8'hFA);
    checkSpot("sub_e2", 2, 8'hAE);
    checkOvf("sub_ovf", 1'b0);
    applyStimulus(3'b100, 2'b00, specA, specB, 8'd0, 1'b0);
    step();
    checkSpot("trn_e0", 0, 8'd2);
    checkSpot("trn_e1", 1, 8'd5);
    checkSpot("trn_e5", 5, 8'd32);
    checkSpot("trn_e6", 6, 8'd18);
    checkSpot("trn_e2", 2, 8'd0);
    checkSpot("trn_e24", 24, 8'd0);

    for (int i = 0; i < 20; i++) begin
      case (vecs[i].matSel)
        0: begin a = specA; b = specB; end
        1: begin a = rndA;  b = rndB;  end
        default: begin a = extA; b = extB; end
      endcase
      applyStimulus(vecs[i].op, vecs[i].size, a, b, vecs[i].scl, 1'b0);
      model(vecs[i].op, vecs[i].size, a, b, vecs[i].scl, r, o);
      pushExp(r, o);
      step();
      checkOutput($sformatf("vec%0d_op%0b_sz%0b", i, vecs[i].op, vecs[i].size));
    end

    runDet("det2_spec", specA, 2'b00, 1'b1);
    checkSpot("det2_spec_e0", 0, 8'h84);
    checkOvf("det2_spec_ovf", 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    pushExp('0, 1'b0);
    checkOutput("det2_after_reset");

    runDet("det3_singular", pack(sing), 2'b01, 1'b1);
    checkSpot("det3_singular_e0", 0, 8'd0);
    runDet("det3_swap", pack(swp3), 2'b01, 1'b1);
    runDet("det4_swap", pack(swp4), 2'b10, 1'b1);
    runDet("det5_small", small5, 2'b11, 1'b1);
    runDet("det5_full", full5, 2'b11, 1'b1);
    runDet("det3_restart", pack(m3), 2'b01, 1'b0);

    // Abort: leave op 110 while the engine is busy, then come back without a start.
    applyStimulus(3'b110, 2'b01, pack(m3), '0, 8'd0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    applyStimulus(3'b110, 2'b01, pack(m3), '0, 8'd0, 1'b1);
    step();
    start = 1'b0;
    applyStimulus(3'b000, 2'b11, specA, specB, 8'd0, 1'b0);
    model(3'b000, 2'b11, specA, specB, 8'd0, r, o);
    pushExp(r, o);
    step();
    checkOutput("abort_follows_add");
    applyStimulus(3'b110, 2'b01, pack(m3), '0, 8'd0, 1'b0);
    repeat (32) step();
    pushExp('0, 1'b0);
    checkOutput("abort_no_result");

    // Reset while the engine is busy discards the partial result.
    applyStimulus(3'b110, 2'b01, pack(m3), '0, 8'd0, 1'b1);
    step();
    start = 1'b0;
    step();
    rst = 1'b0;
    step();
    pushExp('0, 1'b0);
    checkOutput("midreset_zero");
    rst = 1'b1;
    repeat (32) step();
    pushExp('0, 1'b0);
    checkOutput("midreset_stays_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
